// File: rtl/ysyx_22040127_fetch_pkg.sv
// Shared fetch-stage definitions: IF->ID bus layout, reset PC default and
// a word-alignment helper used on redirect targets.
package ysyx_22040127_fetch_pkg;

  localparam int unsigned IF_TO_ID_WIDTH   = 64;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Bus field offsets: {inst, pc}
  localparam int unsigned INST_MSB = 63;
  localparam int unsigned INST_LSB = 32;
  localparam int unsigned PC_MSB   = 31;
  localparam int unsigned PC_LSB   = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_to_id_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22040127_fetch_fifo.sv
// Synchronous FIFO with a flush that empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module ysyx_22040127_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next state; flush wins over push/pop.
  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ysyx_22040127_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under
// a credit limit, buffers returned words and hands {inst, pc} to decode.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module ysyx_22040127_fetch
  import ysyx_22040127_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [31:0]               imem_req_addr,
  input  logic                      imem_resp_valid,
  input  logic [31:0]               imem_resp_data,
  input  logic                      id_allowin,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
  input  logic                      id_branch_taken,
  input  logic [31:0]               id_branch_result
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]               perf_fetched,
  output logic [63:0]               perf_flushed,
  output logic [63:0]               perf_stall
`endif
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic             en_q;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] out_cnt, out_nxt, buf_cnt;
  logic [SUM_W-1:0] credit_used;
  logic             req_fire, redirect, pop, drop_resp, push;
  logic             pcq_full, pcq_empty, buf_full, buf_empty;
  logic [31:0]      req_pc_head;
  if_to_id_t        buf_din, buf_head;

  // Outstanding requests are tracked by the request-PC FIFO occupancy;
  // dropped responses keep holding credit until they return.
  assign credit_used    = SUM_W'(buf_cnt) + SUM_W'(out_cnt);
  assign imem_req_valid = en_q && (credit_used < SUM_W'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign redirect       = id_branch_taken && id_allowin;
  assign if_to_id_valid = !buf_empty;
  assign pop            = if_to_id_valid && id_allowin;
  assign drop_resp      = imem_resp_valid && ((drop_q != '0) || redirect);
  assign push           = imem_resp_valid && !drop_resp;

  assign buf_din.inst = imem_resp_data;
  assign buf_din.pc   = req_pc_head;

  assign if_to_id_bus[INST_MSB:INST_LSB] = if_to_id_valid ? buf_head.inst : '0;
  assign if_to_id_bus[PC_MSB:PC_LSB]     = if_to_id_valid ? buf_head.pc   : '0;

  ysyx_22040127_fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pc_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (req_fire),
    .pop_i   (imem_resp_valid),
    .flush_i (1'b0),
    .data_i  (pc_q),
    .data_o  (req_pc_head),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (out_cnt)
  );

  ysyx_22040127_fetch_fifo #(.WIDTH(IF_TO_ID_WIDTH), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  (buf_din),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_cnt)
  );

  // PC and drop-count next state. On redirect every request still in flight
  // after this cycle (including one firing now) becomes a drop; this equals
  // the next outstanding count and subsumes any drops already pending.
  always_comb begin
    out_nxt = out_cnt + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    pc_d    = pc_q;
    if (redirect)      pc_d = align_word(id_branch_result);
    else if (req_fire) pc_d = pc_q + 32'd4;
    drop_d = drop_q;
    if (redirect)                                drop_d = out_nxt;
    else if (imem_resp_valid && drop_q != '0)    drop_d = drop_q - CNT_W'(1);
  end

  // Fetch enable, PC and drop-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      en_q   <= 1'b1;
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  a_no_buf_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && buf_full && !pop));
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    !(imem_resp_valid && pcq_empty));
  a_no_pcq_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(req_fire && pcq_full));

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetched_q, flushed_q, stall_q, flush_inc;

  // Flushed entries exclude the head, which still handshakes on redirect.
  always_comb begin
    flush_inc = 64'(drop_resp);
    if (redirect) flush_inc = flush_inc + 64'(buf_cnt) - 64'(pop);
  end

  // Free-running performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_q + 64'(push);
      flushed_q <= flushed_q + flush_inc;
      stall_q   <= stall_q + 64'(!if_to_id_valid && id_allowin);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
  assign perf_stall   = stall_q;
`endif

endmodule
